// File: rtl/motor_rodada_param.sv
`default_nettype none
// ============================================================================
// Module   : motor_rodada_param
// Brief    : Parametrised playback/check round engine for the note-memory game
// Revision : 1.0 - initial release
// ============================================================================
module motor_rodada_param #(
  parameter int NOTAS     = 7,
  parameter int PROF      = 16,
  parameter int T_NOTA    = 500,
  parameter int T_PAUSA   = 100,
  parameter int T_JOGADA  = 5000,
  parameter int MAX_ERROS = 3,
  localparam int AW       = $clog2(PROF)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             seq_we,
  input  logic [AW-1:0]    seq_addr,
  input  logic [NOTAS-1:0] seq_data,
  input  logic [AW:0]      seq_len,
  input  logic             iniciar,
  input  logic [NOTAS-1:0] botoes,
  output logic [NOTAS-1:0] leds,
  output logic             acertou,
  output logic             errou,
  output logic [AW:0]      rodada,
  output logic [3:0]       erros,
  output logic [7:0]       pontos,
  output logic             fim_jogo,
  output logic             venceu,
  output logic [2:0]       db_estado
);

  localparam int c_TMAX = (T_NOTA > T_PAUSA)
                        ? ((T_NOTA  > T_JOGADA) ? T_NOTA  : T_JOGADA)
                        : ((T_PAUSA > T_JOGADA) ? T_PAUSA : T_JOGADA);
  localparam int c_TW = $clog2(c_TMAX + 1);
  localparam logic [c_TW-1:0] c_NOTA_END   = c_TW'(T_NOTA - 1);
  localparam logic [c_TW-1:0] c_PAUSA_END  = c_TW'(T_PAUSA - 1);
  localparam logic [c_TW-1:0] c_JOGADA_END = c_TW'(T_JOGADA - 1);
  localparam logic [AW:0]     c_PROF       = (AW+1)'(PROF);
  localparam logic [AW:0]     c_ONE        = (AW+1)'(1);
  localparam logic [3:0]      c_MAX_ERROS  = 4'(MAX_ERROS);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LE      = 3'd1,
    S_MOSTRA  = 3'd2,
    S_PAUSA   = 3'd3,
    S_ESPERA  = 3'd4,
    S_COMPARA = 3'd5,
    S_FIM     = 3'd6
  } state_t;

  state_t r_state, w_state_nxt;

  logic [NOTAS-1:0] r_mem [PROF];
  logic [NOTAS-1:0] r_rdata;

  logic             r_mode, w_mode_nxt;      // 0: playback, 1: checking a press
  logic             r_miss, w_miss_nxt;
  logic [AW-1:0]    r_idx, w_idx_nxt;
  logic [AW:0]      r_rodada, w_rodada_nxt;
  logic [AW:0]      r_len, w_len_nxt;
  logic [3:0]       r_erros, w_erros_nxt;
  logic [7:0]       r_pontos, w_pontos_nxt;
  logic             r_venceu, w_venceu_nxt;
  logic [NOTAS-1:0] r_jog, w_jog_nxt;
  logic [c_TW-1:0]  r_tmr, w_tmr_nxt;
  logic             r_btn_prev;

  logic             w_edge;
  logic             w_last;
  logic             w_match;
  logic [3:0]       w_erros_inc;
  logic [15:0]      w_sum;
  logic             w_ram_open;

  assign w_ram_open  = (r_state == S_IDLE) || (r_state == S_FIM);
  // The press history tracks continuously, so a button held from playback is not a new press.
  assign w_edge      = (|botoes) & ~r_btn_prev;
  assign w_last      = (((AW+1)'(r_idx)) + c_ONE) >= r_rodada;
  assign w_match     = ~r_miss && (r_jog == r_rdata);
  assign w_erros_inc = r_erros + 4'd1;
  assign w_sum       = 16'(r_pontos) + 16'(r_rodada);

  // Song RAM: old data is returned on a same-address write/read collision.
  always_ff @(posedge clock) begin
    if (seq_we && w_ram_open) begin
      r_mem[seq_addr] <= seq_data;
    end
    r_rdata <= r_mem[r_idx];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_miss     <= 1'b0;
      r_idx      <= '0;
      r_rodada   <= '0;
      r_len      <= c_ONE;
      r_erros    <= '0;
      r_pontos   <= '0;
      r_venceu   <= 1'b0;
      r_jog      <= '0;
      r_tmr      <= '0;
      r_btn_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_miss     <= w_miss_nxt;
      r_idx      <= w_idx_nxt;
      r_rodada   <= w_rodada_nxt;
      r_len      <= w_len_nxt;
      r_erros    <= w_erros_nxt;
      r_pontos   <= w_pontos_nxt;
      r_venceu   <= w_venceu_nxt;
      r_jog      <= w_jog_nxt;
      r_tmr      <= w_tmr_nxt;
      r_btn_prev <= |botoes;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mode_nxt   = r_mode;
    w_miss_nxt   = r_miss;
    w_idx_nxt    = r_idx;
    w_rodada_nxt = r_rodada;
    w_len_nxt    = r_len;
    w_erros_nxt  = r_erros;
    w_pontos_nxt = r_pontos;
    w_venceu_nxt = r_venceu;
    w_jog_nxt    = r_jog;
    w_tmr_nxt    = r_tmr;
    leds         = '0;
    acertou      = 1'b0;
    errou        = 1'b0;

    case (r_state)
      S_IDLE, S_FIM: begin
        if (iniciar) begin
          if (seq_len == '0)         w_len_nxt = c_ONE;
          else if (seq_len > c_PROF) w_len_nxt = c_PROF;
          else                       w_len_nxt = seq_len;
          w_rodada_nxt = c_ONE;
          w_idx_nxt    = '0;
          w_erros_nxt  = '0;
          w_pontos_nxt = '0;
          w_venceu_nxt = 1'b0;
          w_mode_nxt   = 1'b0;
          w_miss_nxt   = 1'b0;
          w_tmr_nxt    = '0;
          w_state_nxt  = S_LE;
        end
      end

      S_LE: begin
        w_tmr_nxt   = '0;
        w_state_nxt = r_mode ? S_COMPARA : S_MOSTRA;
      end

      S_MOSTRA: begin
        leds = r_rdata;
        if (r_tmr == c_NOTA_END) begin
          w_tmr_nxt   = '0;
          w_state_nxt = S_PAUSA;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      S_PAUSA: begin
        if (r_tmr == c_PAUSA_END) begin
          w_tmr_nxt = '0;
          if (!w_last) begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_LE;
          end else begin
            w_idx_nxt   = '0;
            w_state_nxt = S_ESPERA;
          end
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      S_ESPERA: begin
        leds = botoes;
        // A press in the timeout cycle still counts as a press.
        if (w_edge) begin
          w_jog_nxt   = botoes;
          w_miss_nxt  = 1'b0;
          w_mode_nxt  = 1'b1;
          w_state_nxt = S_LE;
        end else if (r_tmr == c_JOGADA_END) begin
          w_miss_nxt  = 1'b1;
          w_state_nxt = S_COMPARA;
        end else begin
          w_tmr_nxt = r_tmr + 1'b1;
        end
      end

      S_COMPARA: begin
        leds       = botoes;
        w_miss_nxt = 1'b0;
        w_tmr_nxt  = '0;
        if (w_match) begin
          acertou = 1'b1;
          if (!w_last) begin
            w_idx_nxt   = r_idx + 1'b1;
            w_state_nxt = S_ESPERA;
          end else begin
            w_pontos_nxt = (w_sum > 16'd255) ? 8'd255 : w_sum[7:0];
            if (r_rodada == r_len) begin
              w_venceu_nxt = 1'b1;
              w_state_nxt  = S_FIM;
            end else begin
              w_rodada_nxt = r_rodada + c_ONE;
              w_idx_nxt    = '0;
              w_mode_nxt   = 1'b0;
              w_state_nxt  = S_LE;
            end
          end
        end else begin
          errou        = 1'b1;
          w_erros_nxt  = w_erros_inc;
          w_pontos_nxt = (r_pontos == 8'd0) ? 8'd0 : r_pontos - 8'd1;
          if (w_erros_inc >= c_MAX_ERROS) begin
            w_venceu_nxt = 1'b0;
            w_state_nxt  = S_FIM;
          end else begin
            w_idx_nxt   = '0;
            w_mode_nxt  = 1'b0;
            w_state_nxt = S_LE;
          end
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign rodada    = r_rodada;
  assign erros     = r_erros;
  assign pontos    = r_pontos;
  assign fim_jogo  = (r_state == S_FIM);
  assign venceu    = r_venceu;
  assign db_estado = r_state;

endmodule
`default_nettype wire

// File: tb/tb_motor_rodada_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_rodada_param
// Brief    : Directed self-checking bench; a 12-note/32-deep copy mirrors the
//            7-note instance with notes shifted into the upper bits
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_rodada_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       seq_we;
  logic [3:0] seq_addr;
  logic [6:0] seq_data;
  logic [4:0] seq_len;
  logic       iniciar;
  logic [6:0] botoes;

  logic [6:0] leds;
  logic       acertou, errou, fim_jogo, venceu;
  logic [4:0] rodada;
  logic [3:0] erros;
  logic [7:0] pontos;
  logic [2:0] db_estado;

  logic [11:0] leds_b;
  logic        acertou_b, errou_b, fim_jogo_b, venceu_b;
  logic [5:0]  rodada_b;
  logic [3:0]  erros_b;
  logic [7:0]  pontos_b;
  logic [2:0]  db_estado_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  motor_rodada_param #(
    .NOTAS(7), .PROF(16), .T_NOTA(4), .T_PAUSA(2), .T_JOGADA(20), .MAX_ERROS(3)
  ) u_dut (
    .clock(clock), .reset(reset), .seq_we(seq_we), .seq_addr(seq_addr),
    .seq_data(seq_data), .seq_len(seq_len), .iniciar(iniciar), .botoes(botoes),
    .leds(leds), .acertou(acertou), .errou(errou), .rodada(rodada), .erros(erros),
    .pontos(pontos), .fim_jogo(fim_jogo), .venceu(venceu), .db_estado(db_estado)
  );

  motor_rodada_param #(
    .NOTAS(12), .PROF(32), .T_NOTA(4), .T_PAUSA(2), .T_JOGADA(20), .MAX_ERROS(3)
  ) u_dut_b (
    .clock(clock), .reset(reset), .seq_we(seq_we), .seq_addr({1'b0, seq_addr}),
    .seq_data({seq_data, 5'b0}), .seq_len({1'b0, seq_len}), .iniciar(iniciar),
    .botoes({botoes, 5'b0}),
    .leds(leds_b), .acertou(acertou_b), .errou(errou_b), .rodada(rodada_b),
    .erros(erros_b), .pontos(pontos_b), .fim_jogo(fim_jogo_b), .venceu(venceu_b),
    .db_estado(db_estado_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
    int n = 0;
    while (db_estado != code && n < budget) begin
      step();
      n++;
    end
    chk(tag, db_estado, code);
  endtask

  task automatic load(input int a, input logic [6:0] d);
    seq_we   = 1'b1;
    seq_addr = 4'(a);
    seq_data = d;
    step();
    seq_we   = 1'b0;
  endtask

  task automatic start(input logic [4:0] len);
    seq_len = len;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  // Press lands in ESPERA, then LE, then COMPARA where the verdict pulses.
  task automatic press(input logic [6:0] note, input logic exp_ok, input string tag);
    wait_state(3'd4, 400, {tag, "_wait"});
    botoes = note;
    step();
    botoes = '0;
    step();
    chk({tag, "_acertou"}, acertou, exp_ok);
    chk({tag, "_errou"}, errou, !exp_ok);
    step();
  endtask

  initial begin
    reset = 1'b1; seq_we = 1'b0; seq_addr = '0; seq_data = '0;
    seq_len = '0; iniciar = 1'b0; botoes = '0;
    step(); step();
    reset = 1'b0;
    chk("rst_estado", db_estado, 0);
    chk("rst_leds", leds, 0);
    chk("rst_rodada", rodada, 0);
    chk("rst_pontos", pontos, 0);
    chk("rst_fim", fim_jogo, 0);
    chk("rst_estado_b", db_estado_b, 0);

    // Song 1,2,4,8 played through correctly
    for (int i = 0; i < 4; i++) load(i, 7'(1 << i));
    start(5'd4);
    chk("s1_le", db_estado, 1);
    chk("s1_rodada", rodada, 1);
    step();
    chk("s1_mostra", db_estado, 2);
    chk("s1_leds", leds, 7'h01);
    chk("s1_leds_b", leds_b, 12'h020);
    repeat (6) step();
    chk("s1_playback_len", db_estado, 4);
    for (int r = 1; r <= 4; r++)
      for (int i = 0; i < r; i++) press(7'(1 << i), 1'b1, "s1");
    chk("s1_fim", fim_jogo, 1);
    chk("s1_venceu", venceu, 1);
    chk("s1_pontos", pontos, 10);
    chk("s1_erros", erros, 0);
    chk("s1_estado", db_estado, 6);
    chk("s1_fim_b", fim_jogo_b, 1);
    chk("s1_venceu_b", venceu_b, 1);
    chk("s1_pontos_b", pontos_b, 10);

    // Three wrong presses in round 1, the first a two-button chord
    start(5'd4);
    chk("s2_fim_clr", fim_jogo, 0);
    chk("s2_venceu_clr", venceu, 0);
    chk("s2_pontos_clr", pontos, 0);
    press(7'h03, 1'b0, "s2a");
    chk("s2_erros1", erros, 1);
    chk("s2_pontos_floor", pontos, 0);
    press(7'h02, 1'b0, "s2b");
    press(7'h04, 1'b0, "s2c");
    chk("s2_erros3", erros, 3);
    chk("s2_fim", fim_jogo, 1);
    chk("s2_venceu", venceu, 0);
    chk("s2_pontos", pontos, 0);

    // Timeout in round 2
    start(5'd4);
    press(7'h01, 1'b1, "s3r1");
    chk("s3_rodada2", rodada, 2);
    chk("s3_pontos1", pontos, 1);
    wait_state(3'd4, 400, "s3_espera");
    repeat (19) step();
    chk("s3_still_waiting", db_estado, 4);
    chk("s3_no_errou_yet", errou, 0);
    step();
    chk("s3_timeout_state", db_estado, 5);
    chk("s3_timeout_errou", errou, 1);
    step();
    chk("s3_erros", erros, 1);
    chk("s3_replay_rodada", rodada, 2);
    chk("s3_pontos_dec", pontos, 0);
    chk("s3_replay_le", db_estado, 1);

    // Button held from playback into ESPERA is not a press
    botoes = 7'h01;
    wait_state(3'd4, 400, "s4_espera");
    repeat (5) step();
    chk("s4_held_ignored", db_estado, 4);
    botoes = '0;
    step();
    press(7'h01, 1'b1, "s4a");
    press(7'h02, 1'b1, "s4b");
    chk("s4_pontos", pontos, 2);
    chk("s4_rodada", rodada, 3);

    // RAM write during MOSTRA and iniciar during ESPERA are ignored
    wait_state(3'd2, 400, "s5_mostra");
    seq_we = 1'b1; seq_addr = 4'd0; seq_data = 7'h40;
    step();
    seq_we = 1'b0;
    wait_state(3'd4, 400, "s5_espera");
    seq_len = 5'd1;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    chk("s5_iniciar_ignored", db_estado, 4);
    chk("s5_rodada", rodada, 3);
    press(7'h01, 1'b1, "s5a");
    press(7'h02, 1'b1, "s5b");
    press(7'h04, 1'b1, "s5c");
    chk("s5_pontos", pontos, 5);
    chk("s5_rodada4", rodada, 4);

    // Reset during PAUSA
    wait_state(3'd3, 400, "s5_pausa");
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s5_rst_estado", db_estado, 0);
    chk("s5_rst_leds", leds, 0);
    chk("s5_rst_rodada", rodada, 0);
    chk("s5_rst_erros", erros, 0);
    chk("s5_rst_pontos", pontos, 0);
    chk("s5_rst_fim", fim_jogo, 0);
    chk("s5_rst_venceu", venceu, 0);
    chk("s5_rst_pulses", {acertou, errou}, 0);
    chk("s5_rst_pontos_b", pontos_b, 0);

    // seq_len=0 behaves as a one-note song
    start(5'd0);
    press(7'h01, 1'b1, "s6");
    chk("s6_fim", fim_jogo, 1);
    chk("s6_venceu", venceu, 1);
    chk("s6_pontos", pontos, 1);
    chk("s6_rodada", rodada, 1);
    chk("s6_venceu_b", venceu_b, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
